// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code constants, key event type and decoder state encoding for
// the PS/2 set-2 key event queue.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_E1      = 8'hE1;
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_BAT     = 8'hAA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_ERR0    = 8'h00;
    localparam logic [7:0] SC_ERR1    = 8'hFF;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    // Number of bytes swallowed after E1 before the Pause event is emitted.
    localparam logic [2:0] PAUSE_TAIL_LAST = 3'd6;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_E1_SKIP
    } dec_state_t;

    // Keyboard status/handshake bytes that never start or complete a key event.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_BAT) || (b == SC_ECHO) ||
               (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

    // Re-creates the legacy byte-packed view of a complete scan-code sequence.
    function automatic logic [31:0] pack_key(input key_event_t ev, input logic pause);
        logic [31:0] key;
        if (pause)
            key = {16'h0000, SC_E1, PAUSE_CODE};
        else
            case ({ev.ext, ev.brk})
                2'b00:   key = {24'h000000, ev.code};
                2'b10:   key = {16'h0000, SC_E0, ev.code};
                2'b01:   key = {16'h0000, SC_F0, ev.code};
                default: key = {8'h00, SC_E0, SC_F0, ev.code};
            endcase
        return key;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO for decoded key events; a push while full is accepted
// only when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set-2 scan-code decoder producing make/break/Pause key events into a
// FIFO, with a held-key table and a legacy 32-bit last-sequence view.
module ps2_key_event_queue
    import ps2_kbd_pkg::*;
#(
    parameter int          DEPTH         = 8,
    parameter bit          FILTER_REPEAT = 1'b1,
    parameter logic [31:0] RESET_KEY     = 32'h0000_001C
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       en,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [9:0]                 ev_data,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       held_any,
    output logic [31:0]                cur_key
);

    dec_state_t   state, state_nxt;
    logic [2:0]   skip_cnt, skip_cnt_nxt;
    logic         accept;
    logic         gen;
    logic         pause;
    key_event_t   ev;
    logic [511:0] held, held_nxt;
    logic         filtered;
    logic         ev_fire;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         drop;

    assign in_ready = en;
    assign accept   = in_valid & en;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        gen          = 1'b0;
        pause        = 1'b0;
        ev           = '0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == SC_E0)      state_nxt = ST_E0;
                    else if (in_data == SC_F0) state_nxt = ST_F0;
                    else if (in_data == SC_E1) begin
                        state_nxt    = ST_E1_SKIP;
                        skip_cnt_nxt = '0;
                    end else if (!is_ctrl_byte(in_data)) begin
                        gen = 1'b1;
                        ev  = '{ext: 1'b0, brk: 1'b0, code: in_data};
                    end
                end
                ST_E0: begin
                    if (in_data == SC_F0)      state_nxt = ST_E0F0;
                    else if (in_data == SC_E0) state_nxt = ST_E0;
                    else if (in_data == SC_E1 || is_ctrl_byte(in_data)) state_nxt = ST_IDLE;
                    else begin
                        gen       = 1'b1;
                        ev        = '{ext: 1'b1, brk: 1'b0, code: in_data};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_F0: begin
                    if (in_data == SC_E0)      state_nxt = ST_E0;
                    else if (in_data != SC_F0) begin
                        gen       = 1'b1;
                        ev        = '{ext: 1'b0, brk: 1'b1, code: in_data};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_E0F0: begin
                    if (in_data == SC_E0)      state_nxt = ST_E0;
                    else if (in_data != SC_F0) begin
                        gen       = 1'b1;
                        ev        = '{ext: 1'b1, brk: 1'b1, code: in_data};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_E1_SKIP: begin
                    if (skip_cnt == PAUSE_TAIL_LAST) begin
                        gen       = 1'b1;
                        pause     = 1'b1;
                        ev        = '{ext: 1'b1, brk: 1'b0, code: PAUSE_CODE};
                        state_nxt = ST_IDLE;
                    end else begin
                        skip_cnt_nxt = skip_cnt + 3'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Typematic repeats of a held key vanish entirely: no push, no drop, no cur_key change.
    assign filtered = FILTER_REPEAT && !pause && !ev.brk && held[{ev.ext, ev.code}];
    assign ev_fire  = gen & ~filtered;
    assign pop      = ev_valid & ev_ready;
    assign drop     = ev_fire & fifo_full & ~pop;
    assign ev_valid = ~fifo_empty;

    always_comb begin
        held_nxt = held;
        if (ev_fire && !pause) held_nxt[{ev.ext, ev.code}] = ~ev.brk;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            held     <= '0;
            held_any <= 1'b0;
            cur_key  <= RESET_KEY;
            overflow <= 1'b0;
        end else begin
            held     <= held_nxt;
            held_any <= |held_nxt;
            if (ev_fire) cur_key <= pack_key(ev, pause);
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(key_event_t))
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push    (ev_fire),
        .wr_data (ev),
        .pop     (pop),
        .rd_data (ev_data),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: default instance plus a
// FILTER_REPEAT=0 instance sharing the same input stream.
module tb_ps2_key_event_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          en = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          ev_ready = 1'b0;
    logic          clr_ovf = 1'b0;

    logic          in_ready, ev_valid, overflow, held_any;
    logic [9:0]    ev_data;
    logic [CW-1:0] count;
    logic [31:0]   cur_key;

    logic          nf_in_ready, nf_ev_valid, nf_overflow, nf_held_any;
    logic [9:0]    nf_ev_data;
    logic [CW-1:0] nf_count;
    logic [31:0]   nf_cur_key;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b1), .RESET_KEY(32'h0000_001C)) dut (
        .clk(clk), .clrn(clrn), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .count(count), .overflow(overflow), .clr_ovf(clr_ovf), .held_any(held_any),
        .cur_key(cur_key)
    );

    ps2_key_event_queue #(.DEPTH(DEPTH), .FILTER_REPEAT(1'b0), .RESET_KEY(32'h0000_001C)) dut_nf (
        .clk(clk), .clrn(clrn), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(nf_in_ready), .ev_data(nf_ev_data), .ev_valid(nf_ev_valid), .ev_ready(ev_ready),
        .count(nf_count), .overflow(nf_overflow), .clr_ovf(clr_ovf), .held_any(nf_held_any),
        .cur_key(nf_cur_key)
    );

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0; en = 1'b1; in_valid = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pop_event(output logic [9:0] d, output logic ok);
        @(negedge clk);
        ok = ev_valid;
        d  = ev_data;
        ev_ready = 1'b1;
        @(posedge clk);
        #1 ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clrn = 1'b0;
        #1;
        total++; if (ev_valid !== 1'b0) $display("FAIL reset_ev_valid got %b want 0", ev_valid); else passed++;
        total++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
        total++; if (held_any !== 1'b0) $display("FAIL reset_held_any got %b want 0", held_any); else passed++;
        total++; if (cur_key !== 32'h0000_001C) $display("FAIL reset_cur_key got %h want 0000001c", cur_key); else passed++;
        en = 1'b0; #1;
        total++; if (in_ready !== 1'b0) $display("FAIL in_ready_low got %b want 0", in_ready); else passed++;
        en = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL in_ready_high got %b want 1", in_ready); else passed++;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    task automatic test_make_break();
        logic [9:0] d; logic ok;
        do_reset();
        send_byte(8'h1C);
        total++; if (count !== CW'(1)) $display("FAIL mb_count1 got %0d want 1", count); else passed++;
        total++; if (ev_data !== 10'h01C) $display("FAIL mb_latency got %h want 01c", ev_data); else passed++;
        total++; if (held_any !== 1'b1) $display("FAIL mb_held_set got %b want 1", held_any); else passed++;
        send_byte(8'hF0);
        send_byte(8'h1C);
        total++; if (held_any !== 1'b0) $display("FAIL mb_held_clr got %b want 0", held_any); else passed++;
        total++; if (cur_key !== 32'h0000_F01C) $display("FAIL mb_cur_key got %h want 0000f01c", cur_key); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h01C) $display("FAIL mb_ev0 got %h valid %b want 01c", d, ok); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h11C) $display("FAIL mb_ev1 got %h valid %b want 11c", d, ok); else passed++;
        total++; if (ev_valid !== 1'b0) $display("FAIL mb_empty got %b want 0", ev_valid); else passed++;
    endtask

    task automatic test_extended();
        logic [9:0] d; logic ok;
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        total++; if (cur_key !== 32'h00E0_F075) $display("FAIL ext_cur_key got %h want 00e0f075", cur_key); else passed++;
        total++; if (count !== CW'(2)) $display("FAIL ext_count got %0d want 2", count); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h275) $display("FAIL ext_make got %h valid %b want 275", d, ok); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h375) $display("FAIL ext_break got %h valid %b want 375", d, ok); else passed++;
    endtask

    task automatic test_repeat_filter();
        logic [9:0] d; logic ok;
        do_reset();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        total++; if (cur_key !== 32'h0000_001C) $display("FAIL rep_cur_key got %h want 0000001c", cur_key); else passed++;
        send_byte(8'hF0); send_byte(8'h1C);
        total++; if (count !== CW'(2)) $display("FAIL rep_filtered_count got %0d want 2", count); else passed++;
        total++; if (nf_count !== CW'(4)) $display("FAIL rep_unfiltered_count got %0d want 4", nf_count); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h01C) $display("FAIL rep_ev0 got %h valid %b want 01c", d, ok); else passed++;
        pop_event(d, ok);
        total++; if (!ok || d !== 10'h11C) $display("FAIL rep_ev1 got %h valid %b want 11c", d, ok); else passed++;
        // A break for a key that was never made still reaches the queue.
        send_byte(8'hF0); send_byte(8'h2A);
        total++; if (ev_valid !== 1'b1 || ev_data !== 10'h12A) $display("FAIL rep_unheld_break got %h valid %b want 12a", ev_data, ev_valid); else passed++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [7] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0};
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        total++; if (count !== '0) $display("FAIL pause_early got %0d want 0", count); else passed++;
        send_byte(8'h77);
        total++; if (count !== CW'(1)) $display("FAIL pause_count got %0d want 1", count); else passed++;
        total++; if (ev_data !== 10'h277) $display("FAIL pause_event got %h want 277", ev_data); else passed++;
        total++; if (cur_key !== 32'h0000_E177) $display("FAIL pause_cur_key got %h want 0000e177", cur_key); else passed++;
        total++; if (held_any !== 1'b0) $display("FAIL pause_held got %b want 0", held_any); else passed++;
    endtask

    task automatic test_enable_stall();
        do_reset();
        send_byte(8'hE0);
        @(negedge clk);
        en = 1'b0; in_data = 8'hF0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready); else passed++;
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
        send_byte(8'h75);
        total++; if (ev_valid !== 1'b1 || ev_data !== 10'h275) $display("FAIL stall_resume got %h valid %b want 275", ev_data, ev_valid); else passed++;
    endtask

    task automatic test_overflow();
        logic [9:0] d; logic ok;
        logic [9:0] exp_order [8] = '{10'h011, 10'h012, 10'h013, 10'h014,
                                      10'h015, 10'h016, 10'h017, 10'h019};
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
        total++; if (count !== CW'(8)) $display("FAIL ovf_count got %0d want 8", count); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        total++; if (ev_data !== 10'h010) $display("FAIL ovf_head got %h want 010", ev_data); else passed++;
        total++; if (cur_key !== 32'h0000_0018) $display("FAIL ovf_cur_key got %h want 00000018", cur_key); else passed++;
        @(negedge clk); clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
        @(negedge clk); in_data = 8'h19; in_valid = 1'b1; ev_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; ev_ready = 1'b0;
        total++; if (count !== CW'(8)) $display("FAIL pushpop_count got %0d want 8", count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL pushpop_nodrop got %b want 0", overflow); else passed++;
        total++; if (ev_data !== 10'h011) $display("FAIL pushpop_head got %h want 011", ev_data); else passed++;
        @(negedge clk); in_data = 8'h1A; in_valid = 1'b1; clr_ovf = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; clr_ovf = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL drop_beats_clr got %b want 1", overflow); else passed++;
        for (int i = 0; i < 8; i++) begin
            pop_event(d, ok);
            total++; if (!ok || d !== exp_order[i]) $display("FAIL drain_%0d got %h valid %b want %h", i, d, ok, exp_order[i]); else passed++;
        end
        total++; if (ev_valid !== 1'b0 || count !== '0) $display("FAIL drain_empty got valid %b count %0d want 0 0", ev_valid, count); else passed++;
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        send_byte(8'h2A);
        send_byte(8'hE0); send_byte(8'hF0);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        total++; if (cur_key !== 32'h0000_001C) $display("FAIL midrst_cur_key got %h want 0000001c", cur_key); else passed++;
        total++; if (count !== '0 || ev_valid !== 1'b0) $display("FAIL midrst_fifo got count %0d valid %b want 0 0", count, ev_valid); else passed++;
        total++; if (held_any !== 1'b0) $display("FAIL midrst_held got %b want 0", held_any); else passed++;
        @(negedge clk);
        clrn = 1'b1;
        send_byte(8'h75);
        total++; if (ev_valid !== 1'b1 || ev_data !== 10'h075) $display("FAIL midrst_next got %h valid %b want 075", ev_data, ev_valid); else passed++;
        total++; if (cur_key !== 32'h0000_0075) $display("FAIL midrst_cur_key2 got %h want 00000075", cur_key); else passed++;
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat_filter();
        test_pause();
        test_enable_stall();
        test_overflow();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
